// File: rtl/dial_pkg.sv
// Shared types and default geometry for the dial tracker and its residual step.
// Per-instance widths are derived from module parameters; these types describe the default build.
package dial_pkg;

  localparam int DEFAULT_CLICK_BITS     = 10;
  localparam int DEFAULT_DIAL_CLICKS    = 100;
  localparam int DEFAULT_START_POSITION = 50;
  localparam int DEFAULT_RESULT_WIDTH   = 16;

  typedef logic [DEFAULT_CLICK_BITS-1:0]              click_cnt_t;
  typedef logic [$clog2(DEFAULT_DIAL_CLICKS)-1:0]     position_t;
  typedef logic [DEFAULT_RESULT_WIDTH-1:0]            result_t;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    FINAL
  } state_t;

endpackage

// File: rtl/dial_residual_step.sv
// Combinational final move of a residual (< DIAL_CLICKS) from position p; no latency, no backpressure.
// zero_event is the landing flag in mode 0 and the pass-through-zero flag in mode 1.
module dial_residual_step
  import dial_pkg::*;
#(
  parameter int DIAL_CLICKS = DEFAULT_DIAL_CLICKS,
  parameter int POS_W       = $clog2(DIAL_CLICKS)
) (
  input  logic [POS_W-1:0] pos,
  input  logic [POS_W-1:0] residual,
  input  logic             dir,
  input  logic             mode,
  output logic [POS_W-1:0] new_pos,
  output logic             zero_event
);

  localparam logic [POS_W:0] LIM = (POS_W+1)'(DIAL_CLICKS);

  logic [POS_W:0] sum;
  logic [POS_W:0] sum_wrap;
  logic [POS_W:0] left_wrap;
  logic           pass;

  always_comb begin
    sum       = {1'b0, pos} + {1'b0, residual};
    sum_wrap  = sum - LIM;
    left_wrap = {1'b0, pos} + LIM - {1'b0, residual};
    pass      = 1'b0;
    new_pos   = pos;
    if (dir) begin
      if (sum >= LIM) begin
        new_pos = sum_wrap[POS_W-1:0];
        pass    = 1'b1;
      end else begin
        new_pos = sum[POS_W-1:0];
      end
    end else begin
      if (residual > pos) new_pos = left_wrap[POS_W-1:0];
      else                new_pos = pos - residual;
      // Starting on zero and moving left is not a pass; ending exactly on zero is.
      pass = (pos != '0) && (residual >= pos);
    end
    zero_event = mode ? pass : (new_pos == '0);
  end

endmodule

// File: rtl/dial_tracker_mc.sv
// Dial tracker: accepts one rotation at a time, latency 1 + floor(click_count/DIAL_CLICKS) to crossings_valid.
// click_ready is high only in IDLE; whole-turn reduction runs one DIAL_CLICKS step per cycle, then one FINAL cycle.
module dial_tracker_mc
  import dial_pkg::*;
#(
  parameter int CLICK_BITS     = DEFAULT_CLICK_BITS,
  parameter int DIAL_CLICKS    = DEFAULT_DIAL_CLICKS,
  parameter int START_POSITION = DEFAULT_START_POSITION,
  parameter int RESULT_WIDTH   = DEFAULT_RESULT_WIDTH
) (
  input  logic                           clk,
  input  logic                           test_logic_reset,
  input  logic                           count_mode,
  input  logic                           click_valid,
  output logic                           click_ready,
  input  logic                           click_right_left,
  input  logic [CLICK_BITS-1:0]          click_count,
  input  logic                           end_of_file,
  output logic [$clog2(DIAL_CLICKS)-1:0] dial_position,
  output logic                           crossings_valid,
  output logic [CLICK_BITS-1:0]          crossings_count,
  output logic                           total_valid,
  output logic [RESULT_WIDTH-1:0]        total_count,
  output logic                           total_overflow
);

  localparam int POS_W = $clog2(DIAL_CLICKS);
  localparam int SUM_W = ((RESULT_WIDTH > CLICK_BITS) ? RESULT_WIDTH : CLICK_BITS) + 1;
  localparam logic [CLICK_BITS-1:0] DIAL_LIM  = CLICK_BITS'(DIAL_CLICKS);
  localparam logic [POS_W-1:0]      START_POS = POS_W'(START_POSITION);
  localparam logic [SUM_W-1:0]      RES_MAX   = {{(SUM_W-RESULT_WIDTH){1'b0}}, {RESULT_WIDTH{1'b1}}};

  state_t                  state_q, state_d;
  logic                    dir_q;
  logic                    mode_q;
  logic [CLICK_BITS-1:0]   rem_q;
  logic [CLICK_BITS-1:0]   rem_next;
  logic [CLICK_BITS-1:0]   cnt_q;
  logic [POS_W-1:0]        pos_q;
  logic [RESULT_WIDTH-1:0] total_q;
  logic                    ovf_q;
  logic                    tv_q;
  logic                    tv_set;
  logic                    accept;
  logic [POS_W-1:0]        step_pos;
  logic                    step_zero;
  logic [SUM_W-1:0]        sum_ext;

  assign click_ready     = (state_q == IDLE);
  assign accept          = click_valid && click_ready;
  assign rem_next        = rem_q - DIAL_LIM;
  assign crossings_valid = (state_q == FINAL);
  // Mode 0 never increments during REDUCE, so the same add serves both modes.
  assign crossings_count = cnt_q + CLICK_BITS'(step_zero);
  assign sum_ext         = SUM_W'(total_q) + SUM_W'(crossings_count);
  assign tv_set          = end_of_file && (state_q == IDLE) && !accept;
  assign total_valid     = tv_q || tv_set;
  assign dial_position   = pos_q;
  assign total_count     = total_q;
  assign total_overflow  = ovf_q;

  dial_residual_step #(
    .DIAL_CLICKS (DIAL_CLICKS),
    .POS_W       (POS_W)
  ) u_step (
    .pos        (pos_q),
    .residual   (rem_q[POS_W-1:0]),
    .dir        (dir_q),
    .mode       (mode_q),
    .new_pos    (step_pos),
    .zero_event (step_zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (click_count >= DIAL_LIM) ? REDUCE : FINAL;
      REDUCE:  if (rem_next < DIAL_LIM) state_d = FINAL;
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge test_logic_reset) begin
    if (test_logic_reset) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
      rem_q   <= '0;
      cnt_q   <= '0;
      pos_q   <= START_POS;
      total_q <= '0;
      ovf_q   <= 1'b0;
      tv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (tv_set) tv_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            dir_q  <= click_right_left;
            mode_q <= count_mode;
            rem_q  <= click_count;
            cnt_q  <= '0;
          end
        end
        REDUCE: begin
          rem_q <= rem_next;
          if (mode_q) cnt_q <= cnt_q + 1'b1;
        end
        FINAL: begin
          pos_q <= step_pos;
          if (sum_ext > RES_MAX) begin
            total_q <= '1;
            ovf_q   <= 1'b1;
          end else begin
            total_q <= sum_ext[RESULT_WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dial_tracker_mc.sv
// Directed bench: table of rotations with hand-computed counts/positions, plus end-of-file,
// saturation (second instance with RESULT_WIDTH=4) and reset-during-reduce sequences.
module tb_dial_tracker_mc;

  logic       clk = 1'b0;
  logic       test_logic_reset = 1'b1;
  logic       count_mode = 1'b0;
  logic       click_valid = 1'b0;
  logic       click_right_left = 1'b0;
  logic [9:0] click_count = '0;
  logic       end_of_file = 1'b0;

  logic        click_ready, crossings_valid, total_valid, total_overflow;
  logic [6:0]  dial_position;
  logic [9:0]  crossings_count;
  logic [15:0] total_count;

  logic       s_click_ready, s_crossings_valid, s_total_valid, s_total_overflow;
  logic [6:0] s_dial_position;
  logic [9:0] s_crossings_count;
  logic [3:0] s_total_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dial_tracker_mc dut (
    .clk (clk), .test_logic_reset (test_logic_reset), .count_mode (count_mode),
    .click_valid (click_valid), .click_ready (click_ready),
    .click_right_left (click_right_left), .click_count (click_count),
    .end_of_file (end_of_file), .dial_position (dial_position),
    .crossings_valid (crossings_valid), .crossings_count (crossings_count),
    .total_valid (total_valid), .total_count (total_count),
    .total_overflow (total_overflow)
  );

  dial_tracker_mc #(.RESULT_WIDTH(4)) dut_sat (
    .clk (clk), .test_logic_reset (test_logic_reset), .count_mode (count_mode),
    .click_valid (click_valid), .click_ready (s_click_ready),
    .click_right_left (click_right_left), .click_count (click_count),
    .end_of_file (end_of_file), .dial_position (s_dial_position),
    .crossings_valid (s_crossings_valid), .crossings_count (s_crossings_count),
    .total_valid (s_total_valid), .total_count (s_total_count),
    .total_overflow (s_total_overflow)
  );

  typedef struct {
    logic       rst;
    logic       dir;
    logic [9:0] n;
    logic       mode;
    logic       eofm;
    int         ecnt;
    int         epos;
    int         elat;
  } vec_t;

  vec_t vecs[28];

  task automatic check(input string name, input integer act, input integer exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    test_logic_reset = 1'b1;
    click_valid      = 1'b0;
    end_of_file      = 1'b0;
    @(negedge clk);
    test_logic_reset = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the pulse.
  task automatic exec(input string tag, input logic dir, input logic [9:0] n, input logic mode,
                      input logic eofm, input int ecnt, input int epos, input int elat);
    int         lat;
    int         rlow;
    logic       got;
    logic [9:0] cnt;
    check({tag, " ready"}, click_ready, 1);
    click_right_left = dir;
    click_count      = n;
    count_mode       = mode;
    click_valid      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    click_valid = 1'b0;
    count_mode  = ~mode;
    if (eofm) end_of_file = 1'b1;
    lat  = 0;
    rlow = 0;
    got  = 1'b0;
    cnt  = '0;
    while (!got && lat < 2000) begin
      lat++;
      if (!click_ready) rlow++;
      if (eofm) check({tag, " tv_busy"}, total_valid, 0);
      if (crossings_valid) begin
        got = 1'b1;
        cnt = crossings_count;
      end else begin
        @(negedge clk);
      end
    end
    check({tag, " done"}, got, 1);
    check({tag, " count"}, cnt, ecnt);
    check({tag, " latency"}, lat, elat);
    check({tag, " ready_low"}, rlow, elat);
    @(negedge clk);
    check({tag, " pos"}, dial_position, epos);
  endtask

  task automatic run_vec(input int i);
    string tag;
    tag = $sformatf("vec%0d", i);
    if (vecs[i].rst) do_reset();
    exec(tag, vecs[i].dir, vecs[i].n, vecs[i].mode, vecs[i].eofm,
         vecs[i].ecnt, vecs[i].epos, vecs[i].elat);
  endtask

  initial begin
    int pulses;
    int sat_tot[3];
    int sat_ovf[3];
    sat_tot = '{10, 15, 15};
    sat_ovf = '{0, 1, 1};

    //            rst   dir   n     mode  eofm  cnt pos lat
    // AoC example, mode 0
    vecs[0]  = '{1'b1, 1'b0, 10'd68, 1'b0, 1'b0, 0, 82, 1};
    vecs[1]  = '{1'b0, 1'b0, 10'd30, 1'b0, 1'b0, 0, 52, 1};
    vecs[2]  = '{1'b0, 1'b1, 10'd48, 1'b0, 1'b0, 1,  0, 1};
    vecs[3]  = '{1'b0, 1'b0, 10'd5,  1'b0, 1'b0, 0, 95, 1};
    vecs[4]  = '{1'b0, 1'b1, 10'd60, 1'b0, 1'b0, 0, 55, 1};
    vecs[5]  = '{1'b0, 1'b0, 10'd55, 1'b0, 1'b0, 1,  0, 1};
    vecs[6]  = '{1'b0, 1'b0, 10'd1,  1'b0, 1'b0, 0, 99, 1};
    vecs[7]  = '{1'b0, 1'b0, 10'd99, 1'b0, 1'b0, 1,  0, 1};
    vecs[8]  = '{1'b0, 1'b1, 10'd14, 1'b0, 1'b0, 0, 14, 1};
    vecs[9]  = '{1'b0, 1'b0, 10'd82, 1'b0, 1'b0, 0, 32, 1};
    // AoC example, mode 1; end_of_file rises during the last command
    vecs[10] = '{1'b1, 1'b0, 10'd68, 1'b1, 1'b0, 1, 82, 1};
    vecs[11] = '{1'b0, 1'b0, 10'd30, 1'b1, 1'b0, 0, 52, 1};
    vecs[12] = '{1'b0, 1'b1, 10'd48, 1'b1, 1'b0, 1,  0, 1};
    vecs[13] = '{1'b0, 1'b0, 10'd5,  1'b1, 1'b0, 0, 95, 1};
    vecs[14] = '{1'b0, 1'b1, 10'd60, 1'b1, 1'b0, 1, 55, 1};
    vecs[15] = '{1'b0, 1'b0, 10'd55, 1'b1, 1'b0, 1,  0, 1};
    vecs[16] = '{1'b0, 1'b0, 10'd1,  1'b1, 1'b0, 0, 99, 1};
    vecs[17] = '{1'b0, 1'b0, 10'd99, 1'b1, 1'b0, 1,  0, 1};
    vecs[18] = '{1'b0, 1'b1, 10'd14, 1'b1, 1'b0, 0, 14, 1};
    vecs[19] = '{1'b0, 1'b0, 10'd82, 1'b1, 1'b1, 1, 32, 1};
    // Edge moves
    vecs[20] = '{1'b1, 1'b0, 10'd50,   1'b0, 1'b0, 1,  0, 1};
    vecs[21] = '{1'b0, 1'b0, 10'd0,    1'b0, 1'b0, 1,  0, 1};
    vecs[22] = '{1'b0, 1'b0, 10'd100,  1'b1, 1'b0, 1,  0, 2};
    vecs[23] = '{1'b1, 1'b0, 10'd50,   1'b1, 1'b0, 1,  0, 1};
    vecs[24] = '{1'b0, 1'b0, 10'd0,    1'b1, 1'b0, 0,  0, 1};
    vecs[25] = '{1'b1, 1'b1, 10'd1000, 1'b1, 1'b0, 10, 50, 11};
    vecs[26] = '{1'b1, 1'b0, 10'd68,   1'b1, 1'b0, 1, 82, 1};
    vecs[27] = '{1'b0, 1'b1, 10'd0,    1'b0, 1'b0, 0, 82, 1};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst ready", click_ready, 1);
    check("rst pos", dial_position, 50);
    check("rst cvalid", crossings_valid, 0);
    check("rst tvalid", total_valid, 0);
    check("rst total", total_count, 0);
    check("rst ovf", total_overflow, 0);
    test_logic_reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(i);
    check("m0 tv_pre_eof", total_valid, 0);
    end_of_file = 1'b1;
    #1;
    check("m0 tv_eof", total_valid, 1);
    check("m0 total", total_count, 3);
    check("m0 pos", dial_position, 32);
    @(negedge clk);
    exec("m0 post_eof", 1'b0, 10'd32, 1'b0, 1'b0, 1, 0, 1);
    check("m0 total_post", total_count, 4);
    check("m0 tv_sticky", total_valid, 1);

    for (int i = 10; i < 20; i++) run_vec(i);
    check("m1 tv_after_final", total_valid, 1);
    check("m1 total", total_count, 6);

    for (int i = 20; i < 28; i++) run_vec(i);

    // Saturation on the 4-bit-result instance
    do_reset();
    for (int k = 0; k < 3; k++) begin
      exec($sformatf("sat%0d", k), 1'b1, 10'd1000, 1'b1, 1'b0, 10, 50, 11);
      check($sformatf("sat%0d total", k), s_total_count, sat_tot[k]);
      check($sformatf("sat%0d ovf", k), s_total_overflow, sat_ovf[k]);
    end

    // Reset while reducing R900
    do_reset();
    exec("pre_rst", 1'b0, 10'd68, 1'b1, 1'b0, 1, 82, 1);
    click_right_left = 1'b1;
    click_count      = 10'd900;
    count_mode       = 1'b1;
    click_valid      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    click_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid ready_busy", click_ready, 0);
    #1 test_logic_reset = 1'b1;
    #1;
    check("mid ready_async", click_ready, 1);
    check("mid pos_async", dial_position, 50);
    check("mid cvalid_async", crossings_valid, 0);
    @(negedge clk);
    test_logic_reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (crossings_valid) pulses++;
    end
    check("mid no_pulse", pulses, 0);
    exec("post_rst", 1'b0, 10'd68, 1'b1, 1'b0, 1, 82, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
